// File: rtl/mc_ctrl_pkg.sv
// Shared types and select codes for the multicycle control unit.
// Latency: n/a (package); backpressure: n/a.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_ALU = 4'd7,
        WB_MEM = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10
    } state_e;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_ANDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_CALL = 4'd10;
    localparam logic [3:0] OP_RET  = 4'd11;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;
    localparam logic [1:0] PC_R7  = 2'b11;

    localparam logic [1:0] B_RT   = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_ONE  = 2'b10;
    localparam logic [1:0] B_ZERO = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    localparam logic [1:0] DST_RD = 2'b00;
    localparam logic [1:0] DST_RT = 2'b01;
    localparam logic [1:0] DST_R7 = 2'b10;

    localparam logic [1:0] WBS_ALU = 2'b00;
    localparam logic [1:0] WBS_MDR = 2'b01;
    localparam logic [1:0] WBS_PC1 = 2'b10;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       addr_sel;
        logic [1:0] alu_b_sel;
        logic [1:0] alu_op;
        logic       rf_we;
        logic [1:0] rf_dst_sel;
        logic [1:0] wb_sel;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state/opcode decode to datapath controls and next state.
// Latency: 0 cycles; backpressure: mem_ready holds FETCH/MEM_RD/MEM_WR.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  state_e           state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output ctrl_t            ctrl,
    output state_e           next_state,
    output logic             done_nxt,
    output logic             illegal_nxt
);

    always_comb begin
        ctrl        = '0;
        next_state  = FETCH;
        done_nxt    = 1'b0;
        illegal_nxt = 1'b0;
        case (state)
            FETCH: begin
                ctrl.mem_rd    = 1'b1;
                ctrl.alu_b_sel = B_ONE;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_INC;
                ctrl.ir_we     = mem_ready;
                ctrl.pc_we     = mem_ready;
                next_state     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                case (opcode)
                    OP_AND, OP_ADD, OP_SUB:  next_state = EXEC_R;
                    OP_ADDI, OP_ANDI:        next_state = EXEC_I;
                    OP_LW, OP_SW:            next_state = ADDR;
                    OP_BEQ, OP_BNE:          next_state = BRANCH;
                    OP_JMP, OP_CALL, OP_RET: next_state = JUMP;
                    default: begin
                        // undefined opcode retires as a NOP
                        done_nxt    = 1'b1;
                        illegal_nxt = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                ctrl.alu_b_sel  = B_RT;
                ctrl.alu_op     = (opcode == OP_AND) ? ALU_AND :
                                  (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
                ctrl.rf_dst_sel = DST_RD;
                next_state      = WB_ALU;
            end
            EXEC_I: begin
                ctrl.alu_b_sel  = B_IMM;
                ctrl.alu_op     = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
                ctrl.rf_dst_sel = DST_RT;
                next_state      = WB_ALU;
            end
            WB_ALU: begin
                ctrl.rf_we      = 1'b1;
                ctrl.wb_sel     = WBS_ALU;
                ctrl.rf_dst_sel = (opcode == OP_ADDI || opcode == OP_ANDI) ? DST_RT : DST_RD;
                done_nxt        = 1'b1;
            end
            ADDR: begin
                ctrl.alu_b_sel = B_IMM;
                ctrl.alu_op    = ALU_ADD;
                next_state     = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                ctrl.mem_rd   = 1'b1;
                ctrl.addr_sel = 1'b1;
                next_state    = mem_ready ? WB_MEM : MEM_RD;
            end
            WB_MEM: begin
                ctrl.rf_we      = 1'b1;
                ctrl.wb_sel     = WBS_MDR;
                ctrl.rf_dst_sel = DST_RT;
                done_nxt        = 1'b1;
            end
            MEM_WR: begin
                ctrl.mem_wr   = 1'b1;
                ctrl.addr_sel = 1'b1;
                next_state    = mem_ready ? FETCH : MEM_WR;
                done_nxt      = mem_ready;
            end
            BRANCH: begin
                ctrl.alu_b_sel = B_RT;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_BR;
                ctrl.pc_we     = ((opcode == OP_BEQ) & alu_zero) | ((opcode == OP_BNE) & ~alu_zero);
                done_nxt       = 1'b1;
            end
            JUMP: begin
                ctrl.pc_we  = 1'b1;
                ctrl.pc_src = (opcode == OP_RET) ? PC_R7 : PC_JMP;
                if (opcode == OP_CALL) begin
                    // PC already holds pc+1 from FETCH, so R7 gets the return address
                    ctrl.rf_we      = 1'b1;
                    ctrl.rf_dst_sel = DST_R7;
                    ctrl.wb_sel     = WBS_PC1;
                end
                done_nxt = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: state register, retire/illegal pulse flops, reset gating.
// Latency: 3-5 cycles per instruction; backpressure: mem_ready=0 stretches memory states.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               ir_we,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               addr_sel,
    output logic [1:0]         alu_b_sel,
    output logic [1:0]         alu_op,
    output logic               rf_we,
    output logic [1:0]         rf_dst_sel,
    output logic [1:0]         wb_sel,
    output logic [STATE_W-1:0] state_o,
    output logic               instr_done,
    output logic               illegal
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_g;
    logic   done_d;
    logic   illegal_d;
    logic   done_q;
    logic   illegal_q;

    mc_ctrl_decode #(.OPC_W(OPC_W)) u_decode (
        .state       (state_q),
        .opcode      (opcode),
        .alu_zero    (alu_zero),
        .mem_ready   (mem_ready),
        .ctrl        (ctrl),
        .next_state  (state_d),
        .done_nxt    (done_d),
        .illegal_nxt (illegal_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    // FETCH decodes mem_rd=1, so controls are squashed while reset is held
    assign ctrl_g = rst_n ? ctrl : '0;

    assign pc_we      = ctrl_g.pc_we;
    assign pc_src     = ctrl_g.pc_src;
    assign ir_we      = ctrl_g.ir_we;
    assign mem_rd     = ctrl_g.mem_rd;
    assign mem_wr     = ctrl_g.mem_wr;
    assign addr_sel   = ctrl_g.addr_sel;
    assign alu_b_sel  = ctrl_g.alu_b_sel;
    assign alu_op     = ctrl_g.alu_op;
    assign rf_we      = ctrl_g.rf_we;
    assign rf_dst_sel = ctrl_g.rf_dst_sel;
    assign wb_sel     = ctrl_g.wb_sel;
    assign state_o    = STATE_W'(state_q);
    assign instr_done = done_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench: per-instruction cycle traces built from the ISA rules, checked every cycle.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, mem_rd, mem_wr, addr_sel, rf_we, instr_done, illegal;
    logic [1:0] pc_src, alu_b_sel, alu_op, rf_dst_sel, wb_sel;
    logic [3:0] state_o;

    mc_control_fsm #(.OPC_W(4), .STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr_sel(addr_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .rf_we(rf_we),
        .rf_dst_sel(rf_dst_sel), .wb_sel(wb_sel), .state_o(state_o),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       addr_sel;
        logic [1:0] alu_b_sel;
        logic [1:0] alu_op;
        logic       rf_we;
        logic [1:0] rf_dst_sel;
        logic [1:0] wb_sel;
        logic       instr_done;
        logic       illegal;
    } obs_t;

    typedef struct {
        obs_t e;
        obs_t m;
        bit   mr;
    } cyc_t;

    cyc_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   pend_done = 1'b0;
    bit   pend_ill = 1'b0;

    // strobes, state and pulses are always checked; selects only where the ISA defines them
    function automatic cyc_t blank(state_e s, bit mr);
        cyc_t c;
        c.e = '0;
        c.m = '0;
        c.e.st = s;
        c.m.st = '1;
        c.m.pc_we = 1'b1;
        c.m.ir_we = 1'b1;
        c.m.mem_rd = 1'b1;
        c.m.mem_wr = 1'b1;
        c.m.rf_we = 1'b1;
        c.m.instr_done = 1'b1;
        c.m.illegal = 1'b1;
        c.mr = mr;
        return c;
    endfunction

    function automatic cyc_t fetch_cyc(bit mr);
        cyc_t c;
        c = blank(FETCH, mr);
        c.e.mem_rd = 1'b1;
        c.e.alu_b_sel = 2'b10;
        c.m.alu_b_sel = '1;
        c.m.alu_op = '1;
        c.m.pc_src = '1;
        c.m.addr_sel = 1'b1;
        c.e.pc_we = mr;
        c.e.ir_we = mr;
        return c;
    endfunction

    function automatic logic [1:0] exp_op(logic [3:0] opc);
        case (opc)
            4'd0, 4'd4: return 2'b10;
            4'd2:       return 2'b01;
            default:    return 2'b00;
        endcase
    endfunction

    task automatic reset_cycles();
        cyc_t c;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            mem_ready = 1'($urandom);
            c.e = '0;
            c.e.st = FETCH;
            c.m = '1;
            c.mr = 1'b0;
            sb.push_back(c);
        end
        pend_done = 1'b0;
        pend_ill = 1'b0;
    endtask

    task automatic run_instr(input logic [3:0] opc, input bit az, input int fw, input int mw,
                             input int abort_after);
        cyc_t plan[$];
        cyc_t c;
        bit   rt, it;
        for (int i = 0; i <= fw; i++) begin
            c = fetch_cyc(i == fw);
            if (i == 0) begin
                c.e.instr_done = pend_done;
                c.e.illegal = pend_ill;
            end
            plan.push_back(c);
        end
        plan.push_back(blank(DECODE, 1'($urandom)));
        rt = (opc <= 4'd2);
        it = (opc == 4'd3 || opc == 4'd4);
        if (rt || it) begin
            c = blank(rt ? EXEC_R : EXEC_I, 1'($urandom));
            c.e.alu_b_sel = rt ? 2'b00 : 2'b01;
            c.m.alu_b_sel = '1;
            c.e.alu_op = exp_op(opc);
            c.m.alu_op = '1;
            plan.push_back(c);
            c = blank(WB_ALU, 1'($urandom));
            c.e.rf_we = 1'b1;
            c.m.wb_sel = '1;
            c.e.rf_dst_sel = rt ? 2'b00 : 2'b01;
            c.m.rf_dst_sel = '1;
            plan.push_back(c);
        end else if (opc == 4'd5 || opc == 4'd6) begin
            c = blank(ADDR, 1'($urandom));
            c.e.alu_b_sel = 2'b01;
            c.m.alu_b_sel = '1;
            c.m.alu_op = '1;
            plan.push_back(c);
            for (int i = 0; i <= mw; i++) begin
                c = blank(opc == 4'd5 ? MEM_RD : MEM_WR, i == mw);
                c.e.mem_rd = (opc == 4'd5);
                c.e.mem_wr = (opc == 4'd6);
                c.e.addr_sel = 1'b1;
                c.m.addr_sel = 1'b1;
                plan.push_back(c);
            end
            if (opc == 4'd5) begin
                c = blank(WB_MEM, 1'($urandom));
                c.e.rf_we = 1'b1;
                c.e.wb_sel = 2'b01;
                c.m.wb_sel = '1;
                c.e.rf_dst_sel = 2'b01;
                c.m.rf_dst_sel = '1;
                plan.push_back(c);
            end
        end else if (opc == 4'd7 || opc == 4'd8) begin
            c = blank(BRANCH, 1'($urandom));
            c.m.alu_b_sel = '1;
            c.e.alu_op = 2'b01;
            c.m.alu_op = '1;
            c.e.pc_src = 2'b01;
            c.m.pc_src = '1;
            c.e.pc_we = (opc == 4'd7) ? az : !az;
            plan.push_back(c);
        end else if (opc <= 4'd11) begin
            c = blank(JUMP, 1'($urandom));
            c.e.pc_we = 1'b1;
            c.e.pc_src = (opc == 4'd11) ? 2'b11 : 2'b10;
            c.m.pc_src = '1;
            if (opc == 4'd10) begin
                c.e.rf_we = 1'b1;
                c.e.rf_dst_sel = 2'b10;
                c.m.rf_dst_sel = '1;
                c.e.wb_sel = 2'b10;
                c.m.wb_sel = '1;
            end
            plan.push_back(c);
        end
        for (int i = 0; i < plan.size(); i++) begin
            if (abort_after > 0 && i >= abort_after) break;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            mem_ready = plan[i].mr;
            alu_zero = az;
            opcode = opc;
            sb.push_back(plan[i]);
        end
        if (abort_after > 0) begin
            reset_cycles();
        end else begin
            pend_done = 1'b1;
            pend_ill = (opc >= 4'd12);
        end
    endtask

    always @(negedge clk) begin : monitor
        cyc_t c;
        obs_t a;
        if (sb.size() != 0) begin
            c = sb.pop_front();
            a = {state_o, pc_we, pc_src, ir_we, mem_rd, mem_wr, addr_sel, alu_b_sel, alu_op,
                 rf_we, rf_dst_sel, wb_sel, instr_done, illegal};
            checks++;
            if (((a ^ c.e) & c.m) !== '0) begin
                errors++;
                $display("FAIL trace @%0t st=%0d: got %h want %h (care %h)", $time, c.e.st, a,
                         c.e & c.m, c.m);
            end
            checks++;
            if ((mem_rd && mem_wr) || (rf_we && mem_wr)) begin
                errors++;
                $display("FAIL exclusive @%0t: mem_rd=%b mem_wr=%b rf_we=%b, want no overlap",
                         $time, mem_rd, mem_wr, rf_we);
            end
        end
    end

    initial begin
        int opc, fw, mw, ab;
        reset_cycles();
        run_instr(4'd1, 1'b0, 0, 0, 0);   // ADD
        run_instr(4'd5, 1'b0, 0, 3, 0);   // LW, 3 wait cycles
        run_instr(4'd7, 1'b1, 0, 0, 0);   // BEQ taken
        run_instr(4'd7, 1'b0, 0, 0, 0);   // BEQ not taken
        run_instr(4'd8, 1'b0, 0, 0, 0);   // BNE taken
        run_instr(4'd8, 1'b1, 0, 0, 0);   // BNE not taken
        run_instr(4'd10, 1'b0, 0, 0, 0);  // CALL
        run_instr(4'd11, 1'b0, 0, 0, 0);  // RET
        run_instr(4'd13, 1'b0, 0, 0, 0);  // illegal
        run_instr(4'd6, 1'b0, 2, 2, 0);   // SW with fetch and memory stalls
        run_instr(4'd5, 1'b0, 0, 6, 5);   // LW reset while stalled in MEM_RD
        run_instr(4'd0, 1'b0, 1, 0, 0);
        run_instr(4'd3, 1'b0, 0, 0, 0);
        run_instr(4'd4, 1'b0, 0, 0, 0);
        run_instr(4'd2, 1'b0, 0, 0, 0);
        run_instr(4'd9, 1'b0, 0, 0, 0);
        for (int n = 0; n < 200; n++) begin
            opc = $urandom_range(15);
            fw = ($urandom_range(3) == 0) ? $urandom_range(2, 1) : 0;
            mw = ($urandom_range(2) == 0) ? $urandom_range(3, 1) : 0;
            ab = ($urandom_range(24) == 0) ? $urandom_range(4, 1) : 0;
            run_instr(4'(opc), 1'($urandom), fw, mw, ab);
        end
        run_instr(4'd9, 1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d trace entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
